// File: rtl/diff_commit_collector.sv
// rtl/diff_commit_collector.sv - commit-stage record collector feeding the difftest bridge (optional stats: DIFF_CMT_STATS_EN)
module diff_commit_collector #(
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter logic [31:0] HALT_INSTR  = 32'h80000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  in_valid,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_instr,
    input  logic [1:0]  in_wen,
    input  logic [9:0]  in_wdest,
    input  logic [63:0] in_wdata,
    input  logic [1:0]  in_is_cnt,
    input  logic [63:0] in_timer,
    input  logic [15:0] in_st_valid,
    input  logic [63:0] in_st_paddr,
    input  logic [63:0] in_st_vaddr,
    input  logic [63:0] in_st_data,
    input  logic [15:0] in_ld_valid,
    input  logic [63:0] in_ld_paddr,
    input  logic [63:0] in_ld_vaddr,
    input  logic        in_excp_valid,
    input  logic        in_eret,
    input  logic [5:0]  in_ecode,
    input  logic [10:0] in_intr,
    input  logic [31:0] in_excp_pc,
    input  logic [31:0] in_excp_inst,
    input  logic [31:0] in_a0,
    output logic [7:0]  out_index_0,
    output logic        out_valid_0,
    output logic [63:0] out_pc_0,
    output logic [31:0] out_instr_0,
    output logic        out_wen_0,
    output logic [7:0]  out_wdest_0,
    output logic [63:0] out_wdata_0,
    output logic        out_is_cnt_0,
    output logic [63:0] out_timer_0,
    output logic [7:0]  out_st_index_0,
    output logic [7:0]  out_st_valid_0,
    output logic [63:0] out_st_paddr_0,
    output logic [63:0] out_st_vaddr_0,
    output logic [63:0] out_st_data_0,
    output logic [7:0]  out_ld_index_0,
    output logic [7:0]  out_ld_valid_0,
    output logic [63:0] out_ld_paddr_0,
    output logic [63:0] out_ld_vaddr_0,
    output logic [7:0]  out_index_1,
    output logic        out_valid_1,
    output logic [63:0] out_pc_1,
    output logic [31:0] out_instr_1,
    output logic        out_wen_1,
    output logic [7:0]  out_wdest_1,
    output logic [63:0] out_wdata_1,
    output logic        out_is_cnt_1,
    output logic [63:0] out_timer_1,
    output logic [7:0]  out_st_index_1,
    output logic [7:0]  out_st_valid_1,
    output logic [63:0] out_st_paddr_1,
    output logic [63:0] out_st_vaddr_1,
    output logic [63:0] out_st_data_1,
    output logic [7:0]  out_ld_index_1,
    output logic [7:0]  out_ld_valid_1,
    output logic [63:0] out_ld_paddr_1,
    output logic [63:0] out_ld_vaddr_1,
    output logic        out_excp_valid,
    output logic        out_eret,
    output logic [10:0] out_intrNo,
    output logic [5:0]  out_cause,
    output logic [31:0] out_excp_pc,
    output logic [31:0] out_excp_inst,
    output logic        halt_o,
    output logic        good_trap_o,
    output logic        timeout_o,
    output logic [63:0] stat_instret_o,
    output logic [63:0] stat_cycle_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        is_cnt;
        logic [63:0] timer;
        logic [7:0]  st_valid;
        logic [63:0] st_paddr;
        logic [63:0] st_vaddr;
        logic [63:0] st_data;
        logic [7:0]  ld_valid;
        logic [63:0] ld_paddr;
        logic [63:0] ld_vaddr;
    } rec_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_v0;
    logic        w_v1;
    logic        w_t0;
    logic        w_t1;
    logic        w_trap;
    rec_t        w_src [2];
    rec_t        w_rec [2];
    logic [1:0]  w_out_valid;

    rec_t        r_rec [2];
    logic [1:0]  r_valid;
    logic        r_excp_valid;
    logic        r_eret;
    logic [10:0] r_intr;
    logic [5:0]  r_cause;
    logic [31:0] r_excp_pc;
    logic [31:0] r_excp_inst;
    logic        r_halt;
    logic        r_good_trap;
    logic        r_timeout;
    logic [31:0] r_wd_cnt;

    // Records are only taken while running; draining and halted cycles emit nothing.
    assign w_accept = (r_state == ST_RUN);

    // Widen each raw slot to bridge widths, qualify valids, then compact into output slots.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_src[k].pc       = {32'd0, in_pc[32*k +: 32]};
            w_src[k].instr    = in_instr[32*k +: 32];
            w_src[k].wen      = in_wen[k];
            w_src[k].wdest    = {3'd0, in_wdest[5*k +: 5]};
            w_src[k].wdata    = {32'd0, in_wdata[32*k +: 32]};
            w_src[k].is_cnt   = in_is_cnt[k];
            w_src[k].timer    = in_is_cnt[k] ? in_timer : 64'd0;
            w_src[k].st_valid = in_st_valid[8*k +: 8];
            w_src[k].st_paddr = {32'd0, in_st_paddr[32*k +: 32]};
            w_src[k].st_vaddr = {32'd0, in_st_vaddr[32*k +: 32]};
            w_src[k].st_data  = {32'd0, in_st_data[32*k +: 32]};
            w_src[k].ld_valid = in_ld_valid[8*k +: 8];
            w_src[k].ld_paddr = {32'd0, in_ld_paddr[32*k +: 32]};
            w_src[k].ld_vaddr = {32'd0, in_ld_vaddr[32*k +: 32]};
        end
        w_v0   = w_accept && in_valid[0];
        w_t0   = w_v0 && (in_instr[31:0] == HALT_INSTR);
        // A record behind a trap in slot0 never retires.
        w_v1   = w_accept && in_valid[1] && !w_t0;
        w_t1   = w_v1 && (in_instr[63:32] == HALT_INSTR);
        w_trap = w_t0 || w_t1;
        w_out_valid = {w_v0 && w_v1, w_v0 || w_v1};
        w_rec[0] = '0;
        w_rec[1] = '0;
        if (w_v0) begin
            w_rec[0] = w_src[0];
        end else if (w_v1) begin
            w_rec[0] = w_src[1];
        end
        if (w_v0 && w_v1) begin
            w_rec[1] = w_src[1];
        end
    end

    // Halt/trap state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a retired trap drains for one cycle, then halts until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_trap) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // One-cycle alignment register for commit and exception records.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rec[0]     <= '0;
            r_rec[1]     <= '0;
            r_valid      <= 2'b00;
            r_excp_valid <= 1'b0;
            r_eret       <= 1'b0;
            r_intr       <= '0;
            r_cause      <= '0;
            r_excp_pc    <= '0;
            r_excp_inst  <= '0;
        end else begin
            r_rec[0]     <= w_rec[0];
            r_rec[1]     <= w_rec[1];
            r_valid      <= w_out_valid;
            r_excp_valid <= w_accept && in_excp_valid;
            r_eret       <= w_accept && in_eret;
            r_intr       <= w_accept ? in_intr      : 11'd0;
            r_cause      <= w_accept ? in_ecode     : 6'd0;
            r_excp_pc    <= w_accept ? in_excp_pc   : 32'd0;
            r_excp_inst  <= w_accept ? in_excp_inst : 32'd0;
        end
    end

    // Sticky trap flags: good_trap samples a0 alongside the trap, halt follows the drain cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_halt      <= 1'b0;
            r_good_trap <= 1'b0;
        end else begin
            if (w_trap) begin
                r_good_trap <= (in_a0 == 32'd0);
            end
            if (r_state == ST_DRAIN) begin
                r_halt <= 1'b1;
            end
        end
    end

    // No-commit watchdog: saturating idle counter, frozen once halted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_state != ST_HALTED) begin
            if (in_valid != 2'b00) begin
                r_wd_cnt <= '0;
            end else begin
                if (r_wd_cnt < TIMEOUT_CYC) begin
                    r_wd_cnt <= r_wd_cnt + 32'd1;
                end
                if (r_wd_cnt >= TIMEOUT_CYC - 32'd1) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef DIFF_CMT_STATS_EN
    logic [63:0] r_stat_cycle;
    logic [63:0] r_stat_instret;

    // Cycle and retired-instruction counters, frozen once halted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_cycle   <= '0;
            r_stat_instret <= '0;
        end else if (r_state != ST_HALTED) begin
            r_stat_cycle   <= r_stat_cycle + 64'd1;
            r_stat_instret <= r_stat_instret + {63'd0, r_valid[0]} + {63'd0, r_valid[1]};
        end
    end

    assign stat_cycle_o   = r_stat_cycle;
    assign stat_instret_o = r_stat_instret;
`else
    assign stat_cycle_o   = 64'd0;
    assign stat_instret_o = 64'd0;
`endif

    assign out_valid_0    = r_valid[0];
    assign out_index_0    = 8'd0;
    assign out_st_index_0 = 8'd0;
    assign out_ld_index_0 = 8'd0;
    assign out_pc_0       = r_rec[0].pc;
    assign out_instr_0    = r_rec[0].instr;
    assign out_wen_0      = r_rec[0].wen;
    assign out_wdest_0    = r_rec[0].wdest;
    assign out_wdata_0    = r_rec[0].wdata;
    assign out_is_cnt_0   = r_rec[0].is_cnt;
    assign out_timer_0    = r_rec[0].timer;
    assign out_st_valid_0 = r_rec[0].st_valid;
    assign out_st_paddr_0 = r_rec[0].st_paddr;
    assign out_st_vaddr_0 = r_rec[0].st_vaddr;
    assign out_st_data_0  = r_rec[0].st_data;
    assign out_ld_valid_0 = r_rec[0].ld_valid;
    assign out_ld_paddr_0 = r_rec[0].ld_paddr;
    assign out_ld_vaddr_0 = r_rec[0].ld_vaddr;

    assign out_valid_1    = r_valid[1];
    assign out_index_1    = r_valid[1] ? 8'd1 : 8'd0;
    assign out_st_index_1 = r_valid[1] ? 8'd1 : 8'd0;
    assign out_ld_index_1 = r_valid[1] ? 8'd1 : 8'd0;
    assign out_pc_1       = r_rec[1].pc;
    assign out_instr_1    = r_rec[1].instr;
    assign out_wen_1      = r_rec[1].wen;
    assign out_wdest_1    = r_rec[1].wdest;
    assign out_wdata_1    = r_rec[1].wdata;
    assign out_is_cnt_1   = r_rec[1].is_cnt;
    assign out_timer_1    = r_rec[1].timer;
    assign out_st_valid_1 = r_rec[1].st_valid;
    assign out_st_paddr_1 = r_rec[1].st_paddr;
    assign out_st_vaddr_1 = r_rec[1].st_vaddr;
    assign out_st_data_1  = r_rec[1].st_data;
    assign out_ld_valid_1 = r_rec[1].ld_valid;
    assign out_ld_paddr_1 = r_rec[1].ld_paddr;
    assign out_ld_vaddr_1 = r_rec[1].ld_vaddr;

    assign out_excp_valid = r_excp_valid;
    assign out_eret       = r_eret;
    assign out_intrNo     = r_intr;
    assign out_cause      = r_cause;
    assign out_excp_pc    = r_excp_pc;
    assign out_excp_inst  = r_excp_inst;

    assign halt_o         = r_halt;
    assign good_trap_o    = r_good_trap;
    assign timeout_o      = r_timeout;

endmodule

// File: doc/diff_commit_collector.md
Name: diff_commit_collector

Overview:
- Sits directly upstream of the difftest bridge. Consumes raw commit, store, load and exception records from the core's commit stage (2 commit slots per cycle).
- Registers all records one cycle so they align with the architectural GPR/CSR snapshot the bridge samples.
- Compacts slots, assigns indices and zero-extends to bridge widths.
- Also runs the halt/trap state machine and a no-commit watchdog for the simulation harness.

Parameters:
- TIMEOUT_CYC, 5000, consecutive cycles without any commit before timeout_o asserts
- HALT_INSTR, 32'h80000000, instruction encoding treated as the simulation trap

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous active-high reset
- in_valid  in  2  per-slot commit valid, bit k = slot k
- in_pc  in  64  {slot1, slot0} 32-bit PCs
- in_instr  in  64  {slot1, slot0} instruction words
- in_wen  in  2  per-slot GPR write enable
- in_wdest  in  10  {slot1, slot0} 5-bit destinations
- in_wdata  in  64  {slot1, slot0} write data
- in_is_cnt  in  2  per-slot rdcnt instruction flag
- in_timer  in  64  stable-counter value used by this cycle's rdcnt
- in_st_valid  in  16  {slot1, slot0} 8-bit store type masks (0 = no store)
- in_st_paddr, in_st_vaddr, in_st_data  in  64 each  {slot1, slot0} 32-bit fields
- in_ld_valid  in  16  {slot1, slot0} 8-bit load type masks
- in_ld_paddr, in_ld_vaddr  in  64 each  {slot1, slot0}
- in_excp_valid, in_eret  in  1  exception / ertn taken this cycle
- in_ecode  in  6  exception cause
- in_intr  in  11  pending interrupt vector
- in_excp_pc, in_excp_inst  in  32  faulting PC / instruction
- in_a0  in  32  current GPR r4 value
- out_*  out  —  one bridge-width set per output slot k ∈ {0,1}:
  - index_k 8, valid_k 1, pc_k 64, instr_k 32, wen_k 1, wdest_k 8, wdata_k 64, is_cnt_k 1, timer_k 64
  - st_index_k 8, st_valid_k 8, st_paddr_k / st_vaddr_k / st_data_k 64
  - ld_index_k 8, ld_valid_k 8, ld_paddr_k / ld_vaddr_k 64
  - excp_valid 1, eret 1, intrNo 11, cause 6, excp_pc 32, excp_inst 32
- halt_o  out  1  sticky, trap instruction retired
- good_trap_o  out  1  sticky, a0 == 0 at trap
- timeout_o  out  1  sticky, watchdog expired
- stat_instret_o, stat_cycle_o  out  64 each  statistics (optional feature)

Behaviour:
- Reset: all out_* valids, halt_o, good_trap_o, timeout_o = 0. All data outputs 0. Watchdog counter 0. FSM = RUN.
- Latency: exactly 1 cycle, input cycle N → outputs in cycle N+1. No backpressure; every valid record is emitted once.
- Compaction:
  - in_valid = 2'b10 → slot1 record (commit, store, load) is emitted on out slot 0; out valid = 01.
  - out valid is never 2'b10.
  - index_k = st_index_k = ld_index_k = k, the post-compaction position.
- Width rules: pc, wdata, addresses, data zero-extended to 64; wdest zero-extended to 8.
- timer_k = in_timer registered, only when is_cnt_k; otherwise 0.
- Store/load valid: forced 0 when the owning commit slot is invalid.
- Exceptions: excp fields registered alongside commits. Exception and commits in the same cycle are emitted together. excp_valid and eret are single-cycle pulses.
- FSM:
  - RUN → DRAIN when a valid slot's instr == HALT_INSTR.
    - Commits in that cycle up to and including the trap are emitted.
    - A slot1 record behind a trap in slot0 is dropped.
    - good_trap latches (in_a0 == 0) in the same cycle.
  - DRAIN → HALTED after 1 cycle; halt_o = 1 on entering HALTED.
  - HALTED: all out valids and excp forced 0; stays until reset.
- Watchdog:
  - Counter increments each cycle in RUN/DRAIN with in_valid == 0; clears on any valid commit.
  - At TIMEOUT_CYC: timeout_o = 1 (sticky); counter saturates.
  - Frozen in HALTED.
- Reset asserted mid-operation: next cycle outputs are at reset values; in-flight records are discarded.

Optional Feature:
- DIFF_CMT_STATS_EN defined:
  - stat_cycle_o increments every cycle since reset.
  - stat_instret_o adds popcount(out valid) each cycle.
  - Both freeze in HALTED.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Both slots valid (pc 0x1c000000/0x1c000004, wen 1/1, wdest 5/6) → next cycle valid_0 = valid_1 = 1, pc_0 = 0x000000001c000000, index_1 = 1, wdest_1 = 8'd6.
- in_valid = 10, slot1 store st_valid = 0x04 at paddr 0x80 → out valid 01, pc_0 = slot1 pc, st_valid_0 = 0x04, st_index_0 = 0, st_valid_1 = 0.
- Exception (ecode 0x0b, excp_pc 0x1c000010) in the same cycle as slot0 commit → both outputs next cycle, excp_valid high exactly 1 cycle.
- HALT_INSTR in slot0, slot1 valid, in_a0 = 0 → only slot0 emitted; halt_o = 1 two cycles later; good_trap_o = 1; later inputs produce no valids.
- Same as above with in_a0 = 3 → halt_o = 1, good_trap_o = 0.
- TIMEOUT_CYC = 8, no commits for 8 cycles → timeout_o rises on the 8th idle cycle. Reset pulse clears it, all valids 0 the next cycle.
